bcd_scan_display: RTL and testbench

Parametrised successor to the fixed 8-bit / 3-digit measurement display path. Takes a binary value (e.g. ultrasonic distance from the divider) on a load strobe and converts it to BCD sequentially (double-dabble, one bit per clock). Latches the result into a display buffer and drives a time-multiplexed N-digit 7-segment display with leading-zero blanking. Sits between the measurement/divider block and the board's anode/segment pins.

---
 rtl/bcd_disp_pkg.sv | 24 ++
 rtl/seg7_encode.sv | 34 +++
 rtl/bcd_scan_display.sv | 183 ++++++++++++++++++
 tb/tb_bcd_scan_display.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared types and glyphs for bcd_scan_display.
// Glyphs are active-high {g,f,e,d,c,b,a}; polarity is applied at the pins.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: nibble to active-high 7-segment pattern.
// Dash takes priority over blank; nibbles 10-15 render blank.
module seg7_encode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  // glyph lookup with dash/blank override
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_dash) begin
      o_seg = SEG_DASH;
    end else if (!i_blank) begin
      case (i_nib)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: sequential double-dabble plus multiplexed 7-seg scan.
// Optional BCD_OVERFLOW_EN adds a sticky overflow output and dash display.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    value,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg
`ifdef BCD_OVERFLOW_EN
  ,
  output logic                overflow
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_shift;
  logic [BW-1:0]     r_scratch;
  logic [BW-1:0]     r_bcd;
  logic [BW-1:0]     w_adj;
  logic [CW-1:0]     r_cnt;
  logic              r_done;
  logic              w_last;
  logic [PW-1:0]     r_pre;
  logic [IW-1:0]     r_idx;
  logic [DIGITS-1:0] w_lz;
  logic [DIGITS-1:0] w_an;
  logic [3:0]        w_nib;
  logic              w_blank;
  logic              w_dash;
  logic [6:0]        w_seg;

`ifdef BCD_OVERFLOW_EN
  logic r_sticky;
  logic r_ovf;
  assign overflow = r_ovf;
  assign w_dash   = r_ovf;
`else
  assign w_dash   = 1'b0;
`endif

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (load) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_LATCH;
      S_LATCH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // add-3 to every scratch nibble >= 5 before the shift
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
    end
  end

  // conversion datapath and display buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
`ifdef BCD_OVERFLOW_EN
      r_sticky  <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift   <= value;
            r_scratch <= '0;
            r_cnt     <= '0;
`ifdef BCD_OVERFLOW_EN
            r_sticky  <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          r_shift   <= r_shift << 1;
          r_scratch <= BW'({w_adj, r_shift[WIDTH-1]});
          r_cnt     <= r_cnt + CW'(1);
`ifdef BCD_OVERFLOW_EN
          r_sticky  <= r_sticky | w_adj[BW-1];
`endif
        end
        S_LATCH: begin
          r_bcd  <= r_scratch;
          r_done <= 1'b1;
`ifdef BCD_OVERFLOW_EN
          r_ovf  <= r_sticky;
`endif
        end
        default: ;
      endcase
    end
  end

  // refresh prescaler and scan index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PW'(REFRESH_DIV - 1)) begin
      r_pre <= '0;
      if (r_idx == IW'(DIGITS - 1)) r_idx <= '0;
      else                          r_idx <= r_idx + IW'(1);
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // leading-zero mask: digit i and everything above it is zero
  always_comb begin : lz_scan
    logic v_run;
    v_run = 1'b1;
    w_lz  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_run   = v_run & (r_bcd[4*i +: 4] == 4'd0);
      w_lz[i] = v_run;
    end
  end

  // scan mux: pick digit, anode and blank flag
  always_comb begin
    w_nib   = '0;
    w_an    = '0;
    w_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib   = r_bcd[4*i +: 4];
        w_an[i] = 1'b1;
        w_blank = (i != 0) && w_lz[i];
      end
    end
  end

  seg7_encode u_enc (
    .i_nib   (w_nib),
    .i_blank (w_blank),
    .i_dash  (w_dash),
    .o_seg   (w_seg)
  );

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign bcd  = r_bcd;
  assign an   = ACTIVE_LOW ? ~w_an  : w_an;
  assign seg  = ACTIVE_LOW ? ~w_seg : w_seg;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed + random checks against a decimal model.
// Two instances: 8-bit input and 16-bit input, both 4 digits, REFRESH_DIV=4.
module tb_bcd_scan_display;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  value8 = '0;
  logic        load8 = 1'b0;
  logic        busy8, done8;
  logic [15:0] bcd8;
  logic [3:0]  an8;
  logic [6:0]  seg8;
  logic [15:0] value16 = '0;
  logic        load16 = 1'b0;
  logic        busy16, done16;
  logic [15:0] bcd16;
  logic [3:0]  an16;
  logic [6:0]  seg16;
`ifdef BCD_OVERFLOW_EN
  logic        ovf8, ovf16;
`endif

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  int ndone8 = 0;

  logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  bcd_scan_display #(
    .WIDTH(8), .DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)
  ) u_dut8 (
    .clk(clk), .reset(reset), .value(value8), .load(load8),
    .busy(busy8), .done(done8), .bcd(bcd8), .an(an8), .seg(seg8)
`ifdef BCD_OVERFLOW_EN
    , .overflow(ovf8)
`endif
  );

  bcd_scan_display #(
    .WIDTH(16), .DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)
  ) u_dut16 (
    .clk(clk), .reset(reset), .value(value16), .load(load16),
    .busy(busy16), .done(done16), .bcd(bcd16), .an(an16), .seg(seg16)
`ifdef BCD_OVERFLOW_EN
    , .overflow(ovf16)
`endif
  );

  // clock edges seen since reset released; defines the scan position
  always @(posedge clk or posedge reset)
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;

  always @(posedge clk)
    if (done8 === 1'b1) ndone8++;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic int pow10(input int n);
    int r = 1;
    repeat (n) r *= 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int m;
    m = v % 10000;
    r = '0;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = 4'((m / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx,
                                         input bit ovf);
    int m;
    if (ovf) return ~7'h40;
    m = v % 10000;
    if (idx > 0 && m < pow10(idx)) return 7'h7F;
    return ~GLYPH[(m / pow10(idx)) % 10];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input string tag, input logic [3:0] an_o,
                      input logic [6:0] seg_o, input int v, input bit ovf);
    int idx;
    logic [3:0] ea;
    idx = (ncyc / 4) % 4;
    ea  = ~(4'b0001 << idx);
    chk({tag, "_an"}, 32'(an_o), 32'(ea));
    chk({tag, "_seg"}, 32'(seg_o), 32'(exp_seg(v, idx, ovf)));
  endtask

  task automatic sweep(input int sel, input int v, input bit ovf);
    repeat (16) begin
      tick();
      if (sel != 0) disp("disp16", an16, seg16, v, ovf);
      else          disp("disp8", an8, seg8, v, ovf);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy8), 32'd0);
    chk({tag, "_done"}, 32'(done8), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd8), 32'd0);
    chk({tag, "_an"}, 32'(an8), 32'hE);
    chk({tag, "_seg"}, 32'(seg8), 32'h40);
  endtask

  task automatic conv(input int sel, input int v);
    int w;
    w = (sel != 0) ? 16 : 8;
    if (sel != 0) begin value16 = 16'(v); load16 = 1'b1; end
    else          begin value8  = 8'(v);  load8  = 1'b1; end
    tick();
    load8  = 1'b0;
    load16 = 1'b0;
    chk("busy_rise", 32'((sel != 0) ? busy16 : busy8), 32'd1);
    repeat (w) tick();
    chk("busy_hold", 32'((sel != 0) ? busy16 : busy8), 32'd1);
    chk("done_early", 32'((sel != 0) ? done16 : done8), 32'd0);
    tick();
    chk("done_pulse", 32'((sel != 0) ? done16 : done8), 32'd1);
    chk("busy_fall", 32'((sel != 0) ? busy16 : busy8), 32'd0);
    chk("bcd", 32'((sel != 0) ? bcd16 : bcd8), 32'(to_bcd(v)));
`ifdef BCD_OVERFLOW_EN
    chk("ovf", 32'((sel != 0) ? ovf16 : ovf8), 32'(v >= 10000));
`endif
    tick();
    chk("done_clear", 32'((sel != 0) ? done16 : done8), 32'd0);
  endtask

  initial begin
    int n0;
    int v;
    bit ovf_on;
`ifdef BCD_OVERFLOW_EN
    ovf_on = 1'b1;
`else
    ovf_on = 1'b0;
`endif

    // power-on reset
    #2 reset = 1'b1;
    #1 chk_reset("rst_async0");
    tick();
    tick();
    chk_reset("rst_hold");
    reset = 1'b0;

    // 255 -> 0255, scan 5,5,2,blank
    conv(0, 255);
    sweep(0, 255, 1'b0);

    // second load while busy is ignored
    n0 = ndone8;
    value8 = 8'd200;
    load8 = 1'b1;
    tick();
    load8 = 1'b0;
    tick();
    tick();
    chk("ign_busy", 32'(busy8), 32'd1);
    value8 = 8'd17;
    load8 = 1'b1;
    tick();
    load8 = 1'b0;
    repeat (5) tick();
    chk("ign_early", 32'(done8), 32'd0);
    tick();
    chk("ign_done", 32'(done8), 32'd1);
    chk("ign_bcd", 32'(bcd8), 32'h0200);
    repeat (12) tick();
    chk("ign_idle", 32'(busy8), 32'd0);
    chk("ign_npulse", 32'(ndone8 - n0), 32'd1);
    chk("ign_bcd2", 32'(bcd8), 32'h0200);

    // zero: digit 0 shows '0', rest blank
    conv(0, 0);
    sweep(0, 0, 1'b0);

    // load held high restarts right after latch
    value8 = 8'd123;
    load8 = 1'b1;
    tick();
    repeat (8) tick();
    tick();
    chk("hold_done", 32'(done8), 32'd1);
    chk("hold_bcd", 32'(bcd8), 32'h0123);
    tick();
    chk("hold_restart", 32'(busy8), 32'd1);
    load8 = 1'b0;
    value8 = 8'd7;
    repeat (8) tick();
    tick();
    chk("hold_done2", 32'(done8), 32'd1);
    chk("hold_bcd2", 32'(bcd8), 32'h0123);

    // 16-bit truncation / overflow boundaries
    conv(1, 12345);
    sweep(1, 12345, ovf_on);
    conv(1, 9999);
    sweep(1, 9999, 1'b0);
    conv(1, 10000);
    conv(1, 65535);

    // reset during SHIFT aborts the conversion
    n0 = ndone8;
    value8 = 8'd99;
    load8 = 1'b1;
    tick();
    load8 = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1 chk_reset("rst_mid");
    tick();
    reset = 1'b0;
    repeat (15) tick();
    chk("abort_npulse", 32'(ndone8 - n0), 32'd0);
    chk("abort_bcd", 32'(bcd8), 32'd0);
    chk("abort_busy", 32'(busy8), 32'd0);
    conv(0, 42);
    chk("after_abort", 32'(bcd8), 32'h0042);

    // random 8-bit conversions with display sweep
    repeat (10) begin
      v = int'($urandom_range(0, 255));
      conv(0, v);
      sweep(0, v, 1'b0);
    end

    // random 16-bit conversions
    repeat (10) begin
      v = int'($urandom_range(0, 65535));
      conv(1, v);
    end
    sweep(1, v, ovf_on && (v >= 10000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
